// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing checker: recovers x/y from hsync/vsync, measures line and
// frame timing, declares lock, and reports a per-frame active-pixel checksum.
module vga_sync_monitor #(
  parameter int   H_DISPLAY   = 640,
  parameter int   H_SYNC      = 96,
  parameter int   H_BACK      = 48,
  parameter int   H_TOTAL     = 800,
  parameter int   V_DISPLAY   = 480,
  parameter int   V_SYNC      = 2,
  parameter int   V_BACK      = 33,
  parameter int   V_TOTAL     = 525,
  parameter logic SYNC_POL    = 1'b0,
  parameter int   LOCK_FRAMES = 2
) (
  input  logic        clk_100MHz,
  input  logic        reset,
  input  logic        p_tick,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [11:0] rgb,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        pix_valid,
  output logic [11:0] pix_rgb,
  output logic        locked,
  output logic [10:0] h_period,
  output logic [10:0] v_lines,
  output logic [15:0] frame_sum,
  output logic        frame_done,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  localparam logic [10:0] CNT_MAX  = 11'd2047;
  localparam logic [10:0] H_START  = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] H_END    = 11'(H_SYNC + H_BACK + H_DISPLAY);
  localparam logic [10:0] V_START  = 11'(V_SYNC + V_BACK);
  localparam logic [10:0] V_END    = 11'(V_SYNC + V_BACK + V_DISPLAY);
  localparam logic [10:0] H_TOT_W  = 11'(H_TOTAL);
  localparam logic [10:0] V_TOT_W  = 11'(V_TOTAL);
  localparam logic [10:0] H_SYNC_W = 11'(H_SYNC);
  localparam logic [10:0] V_SYNC_W = 11'(V_SYNC);
  localparam logic [10:0] H_STALL  = 11'(2 * H_TOTAL);
  localparam logic [7:0]  LOCK_N   = 8'(LOCK_FRAMES);

  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return (v == CNT_MAX) ? v : v + 11'd1;
  endfunction

  state_t      state;
  logic        hs_prev, vs_prev;
  logic        h_armed, v_armed, frame_dirty;
  logic [10:0] hcnt, vcnt;
  logic [7:0]  clean_cnt;
  logic [15:0] run_sum;

  logic        hs_lead, hs_trail, vs_lead, vs_trail;
  logic [10:0] hcnt_nxt, vcnt_nxt, period_new, lines_new;
  logic        h_per_err, h_wid_err, v_len_err, v_wid_err, stall, any_err;
  logic        active, clean_frame;
  logic [2:0]  err_inc;
  logic [8:0]  err_sum;
  logic [15:0] sum_nxt;

  assign hs_lead  = (hsync == SYNC_POL) && (hs_prev != SYNC_POL);
  assign hs_trail = (hsync != SYNC_POL) && (hs_prev == SYNC_POL);
  assign vs_lead  = (vsync == SYNC_POL) && (vs_prev != SYNC_POL);
  assign vs_trail = (vsync != SYNC_POL) && (vs_prev == SYNC_POL);

  // The *_nxt counts are the position of the sample being taken this tick.
  assign period_new = sat_inc(hcnt);
  assign lines_new  = sat_inc(vcnt);
  assign hcnt_nxt   = hs_lead ? 11'd0 : sat_inc(hcnt);
  assign vcnt_nxt   = vs_lead ? 11'd0 : (hs_lead ? sat_inc(vcnt) : vcnt);

  assign h_per_err = hs_lead  && h_armed && (period_new != H_TOT_W);
  assign h_wid_err = hs_trail && h_armed && (hcnt_nxt   != H_SYNC_W);
  assign v_len_err = vs_lead  && v_armed && (lines_new  != V_TOT_W);
  assign v_wid_err = vs_trail && v_armed && (vcnt_nxt   != V_SYNC_W);
  // Fires once, on the tick the count first reaches the stall limit.
  assign stall     = !hs_lead && (hcnt != CNT_MAX) && (hcnt_nxt == H_STALL);
  assign any_err   = h_per_err | h_wid_err | v_len_err | v_wid_err | stall;
  assign err_inc   = 3'(h_per_err) + 3'(h_wid_err) + 3'(v_len_err) + 3'(v_wid_err) + 3'(stall);
  assign err_sum   = {1'b0, err_count} + {6'd0, err_inc};

  assign active = (hcnt_nxt >= H_START) && (hcnt_nxt < H_END) &&
                  (vcnt_nxt >= V_START) && (vcnt_nxt < V_END);
  assign sum_nxt = (vs_lead ? 16'd0 : run_sum) + (active ? {4'd0, rgb} : 16'd0);
  assign clean_frame = !frame_dirty && !any_err;

  // NOTE: every register below uses non-blocking assignment so all of them see the
  // same pre-edge values; a blocking write here would leak new state into later lines.
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      state       <= SEARCH;
      hs_prev     <= ~SYNC_POL;
      vs_prev     <= ~SYNC_POL;
      h_armed     <= 1'b0;
      v_armed     <= 1'b0;
      frame_dirty <= 1'b0;
      hcnt        <= '0;
      vcnt        <= '0;
      clean_cnt   <= '0;
      run_sum     <= '0;
      x           <= '0;
      y           <= '0;
      pix_valid   <= 1'b0;
      pix_rgb     <= '0;
      locked      <= 1'b0;
      h_period    <= '0;
      v_lines     <= '0;
      frame_sum   <= '0;
      frame_done  <= 1'b0;
      err_count   <= '0;
    end else begin
      frame_done <= 1'b0;
      if (p_tick) begin
        hs_prev     <= hsync;
        vs_prev     <= vsync;
        hcnt        <= hcnt_nxt;
        vcnt        <= vcnt_nxt;
        run_sum     <= sum_nxt;
        frame_dirty <= vs_lead ? 1'b0 : (frame_dirty | any_err);
        err_count   <= err_sum[8] ? 8'hFF : err_sum[7:0];
        pix_valid   <= active && locked;
        pix_rgb     <= rgb;
        x           <= 10'(hcnt_nxt - H_START);
        y           <= 10'(vcnt_nxt - V_START);

        if (hs_lead) begin
          h_period <= period_new;
          h_armed  <= 1'b1;
        end
        // The first vsync edge after reset or a stall only arms the frame measurement.
        if (vs_lead) begin
          if (v_armed) begin
            frame_sum  <= run_sum;
            v_lines    <= lines_new;
            frame_done <= 1'b1;
          end
          v_armed <= 1'b1;
        end
        // A stall invalidates both measurements in flight, so resynchronise from scratch.
        if (stall) begin
          h_armed <= 1'b0;
          v_armed <= 1'b0;
        end

        case (state)
          SEARCH: begin
            locked    <= 1'b0;
            clean_cnt <= '0;
            if (vs_lead) state <= MEASURE;
          end
          MEASURE: begin
            if (stall) begin
              state     <= SEARCH;
              clean_cnt <= '0;
            end else if (vs_lead) begin
              if (!clean_frame) begin
                clean_cnt <= '0;
              end else if (clean_cnt + 8'd1 >= LOCK_N) begin
                state     <= LOCKED;
                locked    <= 1'b1;
                clean_cnt <= '0;
              end else begin
                clean_cnt <= clean_cnt + 8'd1;
              end
            end else if (any_err) begin
              clean_cnt <= '0;
            end
          end
          LOCKED: begin
            if (any_err) begin
              state  <= SEARCH;
              locked <= 1'b0;
            end
          end
          default: begin
            state  <= SEARCH;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor on a scaled 8x4 timing (16 ticks/line,
// 10 lines/frame) with p_tick asserted every other clock.
module tb_vga_sync_monitor;

  localparam int HD = 8, HS = 2, HB = 2, HT = 16;
  localparam int VD = 4, VS = 2, VB = 2, VT = 10;
  localparam int LF = 2;
  localparam int XS = HS + HB, YS = VS + VB;

  logic        clk_100MHz = 1'b0;
  logic        reset;
  logic        p_tick = 1'b0;
  logic        hsync = 1'b1, vsync = 1'b1;
  logic [11:0] rgb = '0;
  logic [9:0]  x, y;
  logic        pix_valid, locked, frame_done;
  logic [11:0] pix_rgb;
  logic [10:0] h_period, v_lines;
  logic [15:0] frame_sum;
  logic [7:0]  err_count;
  logic [80:0] all_out;

  vga_sync_monitor #(
    .H_DISPLAY(HD), .H_SYNC(HS), .H_BACK(HB), .H_TOTAL(HT),
    .V_DISPLAY(VD), .V_SYNC(VS), .V_BACK(VB), .V_TOTAL(VT),
    .SYNC_POL(1'b0), .LOCK_FRAMES(LF)
  ) dut (
    .clk_100MHz(clk_100MHz), .reset(reset), .p_tick(p_tick),
    .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .x(x), .y(y), .pix_valid(pix_valid), .pix_rgb(pix_rgb), .locked(locked),
    .h_period(h_period), .v_lines(v_lines), .frame_sum(frame_sum),
    .frame_done(frame_done), .err_count(err_count)
  );

  assign all_out = {x, y, pix_valid, pix_rgb, locked, h_period, v_lines,
                    frame_sum, frame_done, err_count};

  always #5 clk_100MHz = ~clk_100MHz;

  int n_tests = 0, n_fail = 0;
  int tick_no, fd_cnt, fd_long = 0, pv_cnt, pv_bad, lock_rise;
  bit locked_seen, first_seen;
  int first_x, first_y, first_h, first_l;
  int line_pv [16];
  logic [15:0] exp_sum;

  task automatic clear_stats();
    tick_no = 0; fd_cnt = 0; pv_cnt = 0; pv_bad = 0; lock_rise = -1;
    locked_seen = 0; first_seen = 0;
    for (int i = 0; i < 16; i++) line_pv[i] = 0;
  endtask

  // One pixel tick followed by one idle clock; h/l give the sample position (-1 = none).
  task automatic tick(input logic hs, input logic vs, input logic [11:0] c,
                      input int h, input int l);
    hsync = hs; vsync = vs; rgb = c; p_tick = 1'b1;
    @(posedge clk_100MHz); #1;
    p_tick = 1'b0;
    if (frame_done) fd_cnt++;
    if (locked && !locked_seen) begin locked_seen = 1; lock_rise = tick_no; end
    if (pix_valid) begin
      pv_cnt++;
      if (!first_seen) begin
        first_seen = 1; first_x = int'(x); first_y = int'(y); first_h = h; first_l = l;
      end
      if (l >= 0 && l < 16) line_pv[l]++;
      if (h < XS || h >= XS + HD || l < YS || l >= YS + VD ||
          int'(x) != h - XS || int'(y) != l - YS || pix_rgb !== c) pv_bad++;
    end
    tick_no++;
    @(posedge clk_100MHz); #1;
    if (frame_done) fd_long++;
  endtask

  function automatic logic [11:0] pix_color(input int mode, input int h, input int l);
    case (mode)
      0:       return 12'hFFF;
      1:       return 12'((h - XS) & 15);
      default: return 12'(2048 + h * 37 + l * 5);
    endcase
  endfunction

  // Sync edges align with line starts, so every frame start is a simultaneous h+v edge.
  task automatic gen_frame(input int mode, input int short_line, input int start_l,
                           input int end_l);
    exp_sum = '0;
    for (int l = start_l; l < end_l; l++) begin
      int len;
      len = (l == short_line) ? HT - 1 : HT;
      for (int h = 0; h < len; h++) begin
        logic [11:0] c;
        c = pix_color(mode, h, l);
        if (h >= XS && h < XS + HD && l >= YS && l < YS + VD) exp_sum += {4'd0, c};
        tick((h < HS) ? 1'b0 : 1'b1, (l < VS) ? 1'b0 : 1'b1, c, h, l);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; #2 reset = 1'b0;
    repeat (3) @(posedge clk_100MHz);
    #1;
    n_tests++; if (all_out !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", all_out); end
    n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b want 0", locked); end
    #2 reset = 1'b1;
  endtask

  task automatic test_nominal();
    clear_stats();
    gen_frame(0, -1, 0, VT);
    n_tests++; if (fd_cnt !== 0) begin n_fail++; $display("FAIL nom_first_edge_arms: frame_done count %0d want 0", fd_cnt); end
    n_tests++; if (h_period !== 11'd16) begin n_fail++; $display("FAIL nom_h_period: got %0d want 16", h_period); end
    gen_frame(0, -1, 0, VT);
    n_tests++; if (fd_cnt !== 1) begin n_fail++; $display("FAIL nom_second_edge_done: frame_done count %0d want 1", fd_cnt); end
    n_tests++; if (v_lines !== 11'd10) begin n_fail++; $display("FAIL nom_v_lines: got %0d want 10", v_lines); end
    n_tests++; if (frame_sum !== 16'd65504) begin n_fail++; $display("FAIL nom_frame_sum_wrap: got %0d want 65504", frame_sum); end
    n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL nom_not_locked_yet: got %b want 0", locked); end
    gen_frame(0, -1, 0, VT);
    n_tests++; if (lock_rise !== 320) begin n_fail++; $display("FAIL nom_lock_third_edge: rose after tick %0d want 320", lock_rise); end
    n_tests++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL nom_err_count: got %0d want 0", err_count); end
    n_tests++; if (pv_cnt !== 32) begin n_fail++; $display("FAIL nom_pix_count: got %0d want 32", pv_cnt); end
    n_tests++; if (fd_long !== 0) begin n_fail++; $display("FAIL nom_done_width: long pulses %0d want 0", fd_long); end
  endtask

  task automatic test_pixels();
    int bad;
    clear_stats();
    gen_frame(1, -1, 0, VT);
    bad = 0;
    for (int l = 0; l < 16; l++) if (line_pv[l] != ((l >= YS && l < YS + VD) ? HD : 0)) bad++;
    n_tests++; if (pv_cnt !== 32) begin n_fail++; $display("FAIL pix_count: got %0d want 32", pv_cnt); end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL pix_per_line: bad lines %0d want 0", bad); end
    n_tests++; if (pv_bad !== 0) begin n_fail++; $display("FAIL pix_xy_rgb: bad samples %0d want 0", pv_bad); end
    n_tests++; if (first_x !== 0 || first_y !== 0) begin n_fail++; $display("FAIL pix_first_xy: got %0d,%0d want 0,0", first_x, first_y); end
    n_tests++; if (first_h !== 4 || first_l !== 4) begin n_fail++; $display("FAIL pix_first_pos: got h%0d l%0d want h4 l4", first_h, first_l); end
    gen_frame(1, -1, 0, VT);
    n_tests++; if (frame_sum !== 16'd112) begin n_fail++; $display("FAIL pix_ramp_sum: got %0d want 112", frame_sum); end
  endtask

  task automatic test_short_line();
    clear_stats();
    gen_frame(0, 5, 0, VT);
    n_tests++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL short_err_count: got %0d want 1", err_count); end
    n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL short_unlock: got %b want 0", locked); end
    clear_stats();
    repeat (3) gen_frame(0, -1, 0, VT);
    n_tests++; if (lock_rise !== 320) begin n_fail++; $display("FAIL short_relock: rose after tick %0d want 320", lock_rise); end
    n_tests++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL short_err_stable: got %0d want 1", err_count); end
    n_tests++; if (fd_cnt !== 3) begin n_fail++; $display("FAIL short_done_count: got %0d want 3", fd_cnt); end
  endtask

  task automatic test_freeze();
    for (int i = 0; i < 200; i++) begin
      @(posedge clk_100MHz); #1;
      hsync = i[0]; vsync = i[3]; rgb = 12'(i);
    end
    hsync = 1'b1; vsync = 1'b1;
    n_tests++; if (err_count !== 8'd1 || locked !== 1'b1) begin n_fail++; $display("FAIL freeze_state: err %0d locked %b want 1,1", err_count, locked); end
    clear_stats();
    gen_frame(0, -1, 0, VT);
    n_tests++; if (err_count !== 8'd1 || locked !== 1'b1 || fd_cnt !== 1) begin
      n_fail++; $display("FAIL freeze_resume: err %0d locked %b done %0d want 1,1,1", err_count, locked, fd_cnt); end
  endtask

  task automatic test_sim_edges();
    logic [15:0] sum2;
    clear_stats();
    gen_frame(2, -1, 0, VT);
    sum2 = exp_sum;
    gen_frame(0, -1, 0, VT);
    n_tests++; if (frame_sum !== sum2) begin n_fail++; $display("FAIL edges_sum: got %0d want %0d", frame_sum, sum2); end
    n_tests++; if (v_lines !== 11'd10 || err_count !== 8'd1) begin n_fail++; $display("FAIL edges_lines_err: lines %0d err %0d want 10,1", v_lines, err_count); end
    n_tests++; if (pv_bad !== 0 || pv_cnt !== 64) begin n_fail++; $display("FAIL edges_pixels: bad %0d count %0d want 0,64", pv_bad, pv_cnt); end
  endtask

  task automatic test_stuck();
    clear_stats();
    repeat (16) tick(1'b1, 1'b1, 12'h0, -1, -1);
    n_tests++; if (err_count !== 8'd1 || locked !== 1'b1) begin n_fail++; $display("FAIL stuck_before_limit: err %0d locked %b want 1,1", err_count, locked); end
    tick(1'b1, 1'b1, 12'h0, -1, -1);
    n_tests++; if (err_count !== 8'd2 || locked !== 1'b0) begin n_fail++; $display("FAIL stuck_at_limit: err %0d locked %b want 2,0", err_count, locked); end
    repeat (16) tick(1'b1, 1'b1, 12'h0, -1, -1);
    n_tests++; if (err_count !== 8'd2) begin n_fail++; $display("FAIL stuck_once: got %0d want 2", err_count); end
    gen_frame(0, -1, 0, VT);
    n_tests++; if (fd_cnt !== 0 || err_count !== 8'd2 || locked !== 1'b0) begin
      n_fail++; $display("FAIL stuck_resume: done %0d err %0d locked %b want 0,2,0", fd_cnt, err_count, locked); end
  endtask

  task automatic test_reset_mid();
    gen_frame(0, -1, 0, 5);
    #2 reset = 1'b0;
    #1;
    n_tests++; if (all_out !== '0) begin n_fail++; $display("FAIL midreset_async: got %h want 0", all_out); end
    n_tests++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL midreset_err: got %0d want 0", err_count); end
    @(posedge clk_100MHz); #2 reset = 1'b1;
    clear_stats();
    gen_frame(0, -1, 3, VT);
    gen_frame(0, -1, 0, VT);
    n_tests++; if (fd_cnt !== 0) begin n_fail++; $display("FAIL midreset_first_edge: done %0d want 0", fd_cnt); end
    gen_frame(0, -1, 0, VT);
    n_tests++; if (fd_cnt !== 1) begin n_fail++; $display("FAIL midreset_second_edge: done %0d want 1", fd_cnt); end
    n_tests++; if (v_lines !== 11'd10 || frame_sum !== 16'd65504 || err_count !== 8'd0) begin
      n_fail++; $display("FAIL midreset_measure: lines %0d sum %0d err %0d want 10,65504,0", v_lines, frame_sum, err_count); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_pixels();
    test_short_line();
    test_freeze();
    test_sim_edges();
    test_stuck();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
